prom_read_ctrl: RTL and testbench
=================================

Name: prom_read_ctrl

Overview:
- Sequencer for the serial configuration PROM readout: runs the PROM reset/chip-enable sequence, clocks out a commanded number of bytes LSB-first, and delivers them over a valid/ready byte stream to the UART transmitter.
- Replaces the free-running dump sequencing: reads are command-driven, byte-exact and back-pressure safe.

Parameters:
- TICK_DIV, 6, clk12m cycles per PROM tick (one prom_clk phase); 6 gives a 1 MHz prom_clk.
- RESET_TICKS, 4, ticks with PROM reset asserted after prom_n_ce falls.
- SETUP_TICKS, 12, ticks between reset release and the first prom_clk rising edge.
- LEN_W, 16, width of the byte-count command.

Ports:
- clk12m  in  1  system clock.
- n_reset  in  1  asynchronous active-low reset.
- cmd_valid  in  1  read request.
- cmd_ready  out  1  high only in IDLE.
- cmd_len  in  LEN_W  bytes to read; 0 means no read.
- abort  in  1  synchronous abort, sampled every clk12m.
- byte_data  out  8  assembled byte.
- byte_valid  out  1  byte_data valid.
- byte_ready  in  1  consumer accepts byte.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a command completes or aborts.
- prom_clk  out  1  PROM serial clock.
- prom_reset  out  1  active-high PROM reset (un-programmed parts).
- prom_n_reset  out  1  active-low PROM reset (always the inverse of prom_reset).
- prom_n_ce  out  1  PROM chip enable, active low.
- prom_data  in  1  PROM serial data, already synchronised externally.

Behaviour:
- Reset values: cmd_ready=1, byte_data=0, byte_valid=0, busy=0, done=0, prom_clk=0, prom_reset=1, prom_n_reset=0, prom_n_ce=1; tick counter=0, all state cleared.
- Tick strobe: asserted one clk12m cycle every TICK_DIV cycles, free-running from reset. All PROM pin changes occur only on tick cycles.
- IDLE:
  - A command is accepted when cmd_valid && cmd_ready.
  - Latch remaining=cmd_len and move to ASSERT.
  - If cmd_len==0, pulse done next cycle and stay in IDLE.
- ASSERT:
  - On the first tick, set prom_n_ce=0 with prom_reset=1.
  - After RESET_TICKS ticks, set prom_reset=0 and go to SETUP.
- SETUP: wait SETUP_TICKS ticks with prom_clk=0, then go to SHIFT.
- SHIFT: prom_clk alternates on ticks, high for one tick and low for one tick.
  - On the tick where prom_clk goes 0→1, sample prom_data into the shift register MSB, shifting right; the first bit received ends up as bit 0.
  - After 8 rising edges the byte is complete.
  - When the falling edge follows, move the byte to the output register: byte_valid=1, remaining -= 1.
  - If the output register is still occupied at byte completion, go to STALL.
- STALL:
  - prom_clk is held low and no ticks are consumed.
  - When the pending byte is accepted, transfer the completed byte on the next tick and resume SHIFT.
  - No PROM bit may be lost or duplicated.
- Output handshake:
  - byte_data and byte_valid are stable while byte_valid && !byte_ready.
  - A transfer occurs on a cycle with byte_valid && byte_ready.
  - The next byte may be presented in the cycle after a transfer.
- Completion:
  - When remaining reaches 0 and the last byte has been transferred, return PROM pins to reset values on the next tick: prom_n_ce=1, prom_reset=1, prom_clk=0.
  - Then pulse done for one cycle and enter IDLE.
- Abort:
  - From any non-IDLE state, go immediately to the completion path.
  - Drop any unsent byte: byte_valid=0.
  - PROM pins return to reset values within one tick; done pulses once.
  - abort in IDLE has no effect.
- Simultaneous abort and byte transfer: the transfer completes, then the abort applies.
- Reset mid-operation: all outputs return to reset values asynchronously; no done pulse.
- Width: remaining is LEN_W bits and never wraps, because 0 is checked before decrement; cmd_len max = 2^LEN_W-1.

Test Plan:
- Single byte, TICK_DIV=2, RESET_TICKS=2, SETUP_TICKS=2, cmd_len=1, prom_data bit sequence 1,0,1,1,0,0,1,0, byte_ready=1 → byte_data=0x4D; exactly 8 prom_clk pulses; prom_n_ce returns to 1; one done pulse.
- Burst of 3 bytes with model PROM content 0xA5,0x3C,0xFF → bytes arrive in order; 24 prom_clk pulses total; prom_n_ce low the whole time.
- Back-pressure: cmd_len=4, byte_ready held 0 for 200 cycles after the first byte → prom_clk stays low during the stall; after release the sequence 0x01,0x02,0x03,0x04 arrives intact.
- Abort in SHIFT after 3 bits of byte 2, cmd_len=5 → byte_valid drops; PROM pins at reset values within TICK_DIV cycles; single done pulse; cmd_ready=1 afterwards.
- cmd_len=0 → no PROM pin activity; done pulses one cycle after acceptance.
- Asynchronous n_reset low mid-burst → all outputs at reset values in the same cycle; a subsequent cmd_len=1 read returns the first PROM byte.

Source files
------------

// File: rtl/prom_read_ctrl.sv
// Purpose : command-driven readout of a serial configuration PROM into a byte stream.
// Latency : ASSERT + SETUP phases, then 16 ticks per byte; byte_valid rises on the falling prom_clk tick after bit 8.
// Backpressure: a byte held by !byte_ready parks the sequencer in STALL with prom_clk low; no PROM bit is lost or repeated.
//
// Ports:
//   clk12m, n_reset            system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_len read request; cmd_len = number of bytes (0 = no read)
//   abort                      synchronous abort of a running read
//   byte_data/byte_valid/byte_ready  output byte stream (valid/ready)
//   busy, done                 status; done pulses once per completed or aborted command
//   prom_clk, prom_reset, prom_n_reset, prom_n_ce, prom_data  PROM pins
module prom_read_ctrl #(
    parameter int TICK_DIV    = 6,
    parameter int RESET_TICKS = 4,
    parameter int SETUP_TICKS = 12,
    parameter int LEN_W       = 16
) (
    input  logic             clk12m,
    input  logic             n_reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort,
    output logic [7:0]       byte_data,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             busy,
    output logic             done,
    output logic             prom_clk,
    output logic             prom_reset,
    output logic             prom_n_reset,
    output logic             prom_n_ce,
    input  logic             prom_data
);

    localparam int             TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]  TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [15:0]    RST_LAST   = 16'(RESET_TICKS - 1);
    localparam logic [15:0]    SETUP_LAST = 16'(SETUP_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_SETUP,
        S_SHIFT,
        S_STALL,
        S_FINISH
    } state_t;

    state_t           state;
    logic [TW-1:0]    tick_cnt;
    logic             tick;
    logic [15:0]      phase_cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic [LEN_W-1:0] remaining;
    logic             xfer;
    logic             out_free;

    // Free-running tick strobe; every PROM pin change is gated by it.
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk12m or negedge n_reset) begin
        if (!n_reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign xfer         = byte_valid && byte_ready;
    // The output register can take a new byte if empty or being drained this cycle.
    assign out_free     = !byte_valid || byte_ready;
    assign prom_n_reset = ~prom_reset;

    always_ff @(posedge clk12m or negedge n_reset) begin
        if (!n_reset) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            prom_clk   <= 1'b0;
            prom_reset <= 1'b1;
            prom_n_ce  <= 1'b1;
            phase_cnt  <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            remaining  <= '0;
        end else begin
            done <= 1'b0;
            // A transfer always completes, even in the cycle an abort arrives.
            if (xfer) begin
                byte_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            remaining <= cmd_len;
                            phase_cnt <= '0;
                            bit_cnt   <= '0;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            state     <= S_ASSERT;
                        end
                    end
                end

                S_FINISH: begin
                    if (abort) begin
                        byte_valid <= 1'b0;
                    end
                    // Normal completion waits until the last byte has left the output register.
                    if (tick && !byte_valid) begin
                        prom_n_ce  <= 1'b1;
                        prom_reset <= 1'b1;
                        prom_clk   <= 1'b0;
                        done       <= 1'b1;
                        cmd_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end

                default: begin
                    if (abort) begin
                        byte_valid <= 1'b0;
                        state      <= S_FINISH;
                    end else if (tick) begin
                        unique case (state)
                            S_ASSERT: begin
                                if (prom_n_ce) begin
                                    prom_n_ce <= 1'b0;
                                    phase_cnt <= '0;
                                end else if (phase_cnt == RST_LAST) begin
                                    prom_reset <= 1'b0;
                                    phase_cnt  <= '0;
                                    state      <= S_SETUP;
                                end else begin
                                    phase_cnt <= phase_cnt + 16'd1;
                                end
                            end

                            S_SETUP: begin
                                // The last setup tick is also the first rising edge.
                                if (phase_cnt == SETUP_LAST) begin
                                    prom_clk  <= 1'b1;
                                    shift_reg <= {prom_data, shift_reg[7:1]};
                                    bit_cnt   <= 4'd1;
                                    state     <= S_SHIFT;
                                end else begin
                                    phase_cnt <= phase_cnt + 16'd1;
                                end
                            end

                            S_SHIFT: begin
                                if (!prom_clk) begin
                                    prom_clk  <= 1'b1;
                                    shift_reg <= {prom_data, shift_reg[7:1]};
                                    bit_cnt   <= bit_cnt + 4'd1;
                                end else begin
                                    prom_clk <= 1'b0;
                                    if (bit_cnt == 4'd8) begin
                                        if (out_free) begin
                                            byte_data  <= shift_reg;
                                            byte_valid <= 1'b1;
                                            remaining  <= remaining - LEN_W'(1);
                                            bit_cnt    <= '0;
                                            state      <= (remaining == LEN_W'(1)) ? S_FINISH : S_SHIFT;
                                        end else begin
                                            state <= S_STALL;
                                        end
                                    end
                                end
                            end

                            S_STALL: begin
                                // prom_clk is already low; the completed byte waits in shift_reg.
                                if (out_free) begin
                                    byte_data  <= shift_reg;
                                    byte_valid <= 1'b1;
                                    remaining  <= remaining - LEN_W'(1);
                                    bit_cnt    <= '0;
                                    state      <= (remaining == LEN_W'(1)) ? S_FINISH : S_SHIFT;
                                end
                            end

                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prom_read_ctrl.sv
// Bench for prom_read_ctrl: table of read transactions, hand-written corner
// sequences (stall, abort, zero length, async reset) and randomized reads
// checked against a PROM model whose expected stream is simply its contents.
module tb_prom_read_ctrl;
    localparam int TICK_DIV    = 2;
    localparam int RESET_TICKS = 2;
    localparam int SETUP_TICKS = 2;
    localparam int LEN_W       = 16;

    logic             clk12m = 1'b0;
    logic             n_reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             abort;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_ready;
    logic             busy;
    logic             done;
    logic             prom_clk;
    logic             prom_reset;
    logic             prom_n_reset;
    logic             prom_n_ce;
    logic             prom_data;

    prom_read_ctrl #(
        .TICK_DIV(TICK_DIV), .RESET_TICKS(RESET_TICKS),
        .SETUP_TICKS(SETUP_TICKS), .LEN_W(LEN_W)
    ) dut (
        .clk12m(clk12m), .n_reset(n_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .abort(abort),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .done(done),
        .prom_clk(prom_clk), .prom_reset(prom_reset), .prom_n_reset(prom_n_reset),
        .prom_n_ce(prom_n_ce), .prom_data(prom_data)
    );

    always #5 clk12m = ~clk12m;

    // PROM model: address counter restarts on reset, advances on each rising prom_clk.
    logic [7:0] prom_mem [64];
    logic [8:0] pidx = '0;
    assign prom_data = prom_mem[pidx[8:3]][pidx[2:0]];
    always @(posedge prom_clk or posedge prom_reset) begin
        if (prom_reset) pidx <= '0;
        else            pidx <= pidx + 9'd1;
    end

    int n_chk = 0, n_pass = 0;
    int pulses = 0, done_cnt = 0, ce_falls = 0, ce_err = 0, stab_err = 0;
    int rdy_mode = 0;       // 0: always ready, 1: random, 2: held low
    logic [7:0] got[$];
    logic pv = 1'b0, pr = 1'b0, pa = 1'b0, pn = 1'b0;
    logic [7:0] pd = '0;

    always @(posedge prom_clk) begin
        pulses++;
        if (prom_n_ce !== 1'b0 || prom_reset !== 1'b0) ce_err++;
    end
    always @(negedge prom_n_ce) ce_falls++;

    always @(negedge clk12m) begin
        if (n_reset) begin
            if (done) done_cnt++;
            if (byte_valid && byte_ready) got.push_back(byte_data);
            if (pv && !pr && !pa && pn && (!byte_valid || byte_data != pd)) stab_err++;
        end
        pv = byte_valid; pr = byte_ready; pa = abort; pd = byte_data; pn = n_reset;
    end

    initial begin
        byte_ready = 1'b0;
        forever begin
            @(posedge clk12m);
            #2;
            if (rdy_mode == 0)      byte_ready = 1'b1;
            else if (rdy_mode == 1) byte_ready = 1'($urandom_range(0, 1));
            else                    byte_ready = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk12m);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_cmd_ready"},    cmd_ready,    1);
        chk({p, "_byte_data"},    byte_data,    0);
        chk({p, "_byte_valid"},   byte_valid,   0);
        chk({p, "_busy"},         busy,         0);
        chk({p, "_done"},         done,         0);
        chk({p, "_prom_clk"},     prom_clk,     0);
        chk({p, "_prom_reset"},   prom_reset,   1);
        chk({p, "_prom_n_reset"}, prom_n_reset, 0);
        chk({p, "_prom_n_ce"},    prom_n_ce,    1);
    endtask

    task automatic send_cmd(input int len);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        @(negedge clk12m);
        chk("cmd_ready_at_issue", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk12m);
            seen = done;
            step();
        end
        chk({name, "_done_seen"}, seen, 1);
    endtask

    // Expected stream: the first len bytes of the PROM, since each read restarts it.
    task automatic run_txn(input string name, input int len, input int mode,
                           input int exp_pulses, input int exp_falls);
        int p0, d0, f0;
        got.delete();
        p0 = pulses; d0 = done_cnt; f0 = ce_falls; ce_err = 0; stab_err = 0;
        rdy_mode = mode;
        send_cmd(len);
        wait_done(4000, name);
        repeat (3) step();
        chk({name, "_pulses"}, pulses - p0, exp_pulses);
        chk({name, "_done_cnt"}, done_cnt - d0, 1);
        chk({name, "_nbytes"}, got.size(), len);
        for (int i = 0; i < len && i < got.size(); i++)
            chk({name, "_byte"}, got[i], prom_mem[i]);
        chk({name, "_ce_falls"}, ce_falls - f0, exp_falls);
        chk({name, "_ce_low_during_clk"}, ce_err, 0);
        chk({name, "_stable"}, stab_err, 0);
        chk({name, "_n_ce_end"}, prom_n_ce, 1);
        chk({name, "_busy_end"}, busy, 0);
    endtask

    typedef struct {
        int          len;
        int          mode;
        logic [31:0] bytes;   // PROM contents, byte i at bits 8*i+7:8*i
        int          exp_pulses;
        int          exp_falls;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int   seq[8];
        logic [7:0] b0;
        int   p0, d0, len;
        bit   seen;

        vecs[0] = '{3, 0, 32'h00FF3CA5, 24, 1};
        vecs[1] = '{0, 0, 32'h00000000, 0,  0};
        vecs[2] = '{2, 1, 32'h0000C35A, 16, 1};
        vecs[3] = '{4, 1, 32'hFE018000, 32, 1};
        for (int i = 0; i < 64; i++) prom_mem[i] = 8'(i * 7 + 3);

        n_reset = 1'b0; cmd_valid = 1'b0; cmd_len = '0; abort = 1'b0;
        repeat (3) step();
        @(negedge clk12m);
        chk_reset_vals("reset");
        step();
        n_reset = 1'b1;
        repeat (2) step();

        // Single byte from an explicit bit stream, first bit = bit 0.
        seq = '{1, 0, 1, 1, 0, 0, 1, 0};
        for (int i = 0; i < 8; i++) b0[i] = seq[i][0];
        prom_mem[0] = b0;
        run_txn("single", 1, 0, 8, 1);
        chk("single_value", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF_FFFF, 32'h4D);

        // Table of transactions.
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 4; i++) prom_mem[i] = vecs[v].bytes[8*i +: 8];
            run_txn($sformatf("vec%0d", v), vecs[v].len, vecs[v].mode,
                    vecs[v].exp_pulses, vecs[v].exp_falls);
        end

        // Zero length: done exactly one cycle after acceptance, no pin activity.
        p0 = pulses; d0 = ce_falls;
        cmd_valid = 1'b1; cmd_len = '0;
        @(negedge clk12m);
        chk("zero_pre_done", done, 0);
        step();
        cmd_valid = 1'b0;
        @(negedge clk12m);
        chk("zero_done_hi", done, 1);
        step();
        @(negedge clk12m);
        chk("zero_done_lo", done, 0);
        chk("zero_no_pulses", pulses - p0, 0);
        chk("zero_no_ce", ce_falls - d0, 0);
        step();

        // Abort in IDLE has no effect.
        d0 = done_cnt;
        abort = 1'b1;
        repeat (3) step();
        abort = 1'b0;
        step();
        chk("idle_abort_done", done_cnt - d0, 0);
        chk("idle_abort_busy", busy, 0);

        // Back-pressure: consumer stalls 200 cycles after the first byte.
        for (int i = 0; i < 4; i++) prom_mem[i] = 8'(i + 1);
        got.delete(); stab_err = 0;
        rdy_mode = 2;
        send_cmd(4);
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk12m);
            seen = byte_valid;
            step();
        end
        chk("bp_first_valid", seen, 1);
        p0 = pulses;
        repeat (200) step();
        @(negedge clk12m);
        chk("bp_stall_pulses", pulses - p0, 8);
        chk("bp_stall_clk_low", prom_clk, 0);
        chk("bp_held_data", byte_data, 8'h01);
        chk("bp_held_valid", byte_valid, 1);
        step();
        rdy_mode = 0;
        wait_done(4000, "bp");
        repeat (3) step();
        chk("bp_nbytes", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("bp_byte", got[i], 32'(i + 1));
        chk("bp_stable", stab_err, 0);

        // Abort after 3 bits of byte 2 with byte 1 still pending.
        for (int i = 0; i < 5; i++) prom_mem[i] = 8'($urandom);
        got.delete();
        rdy_mode = 2;
        send_cmd(5);
        p0 = pulses;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            step();
            seen = (pulses - p0 >= 11);
        end
        chk("abort_reached_bit", seen, 1);
        d0 = done_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk12m);
        chk("abort_valid_drop", byte_valid, 0);
        step();
        step();
        @(negedge clk12m);
        chk("abort_n_ce", prom_n_ce, 1);
        chk("abort_reset", prom_reset, 1);
        chk("abort_n_reset", prom_n_reset, 0);
        chk("abort_clk", prom_clk, 0);
        step();
        repeat (4) step();
        chk("abort_done_once", done_cnt - d0, 1);
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_pulses", pulses - p0, 11);
        chk("abort_no_bytes", got.size(), 0);
        run_txn("after_abort", 1, 0, 8, 1);

        // Asynchronous reset mid-burst, then a fresh read.
        for (int i = 0; i < 3; i++) prom_mem[i] = 8'($urandom);
        rdy_mode = 0;
        send_cmd(3);
        p0 = pulses;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            step();
            seen = (pulses - p0 >= 12);
        end
        chk("arst_reached", seen, 1);
        #2;
        n_reset = 1'b0;
        #1;
        chk_reset_vals("arst");
        d0 = done_cnt;
        repeat (3) step();
        n_reset = 1'b1;
        repeat (2) step();
        chk("arst_no_done", done_cnt - d0, 0);
        run_txn("after_arst", 1, 0, 8, 1);

        // Randomized reads with random consumer back-pressure.
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) prom_mem[i] = 8'($urandom);
            run_txn($sformatf("rand%0d", it), len, 1, 8 * len, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
